// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of an asynchronous input in Clk50M cycles.
// Optional glitch filter enabled by defining PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = 32'd100000
`ifdef PWM_CAP_GLITCH_FILTER_EN
  , parameter int unsigned    FILT_LEN    = 4
`endif
) (
  input  logic             Clk50M,
  input  logic             Rst,
  input  logic             cap_en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_lvl,
  output logic             pwm_level
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, s_q;
  logic             s, rise, fall, timeout, report_to;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;
  logic             valid_q, valid_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT_CYC) ? TIMEOUT_CYC : v + CNT_W'(1);
  endfunction

  // Stage 0: two-flop synchronizer
  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int unsigned FW = $clog2(FILT_LEN + 1);
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Stage 1: level follows the input only after FILT_LEN consecutive differing cycles
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) filt_d = sync2_q;
      else                             fcnt_d = fcnt_q + FW'(1);
    end
  end

  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign s = filt_q;
`else
  assign s = sync2_q;
`endif

  assign rise      = s & ~s_q;
  assign fall      = ~s & s_q;
  assign timeout   = (cnt_q == TIMEOUT_CYC) && !rise && !fall;
  assign pwm_level = s;

  // Stage 2: edge detection, counting and measurement FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = rise ? CNT_W'(1) : sat_inc(cnt_q);
    hi_lat_d    = hi_lat_q;
    period_d    = period_q;
    high_d      = high_q;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;
    valid_d     = 1'b0;
    report_to   = 1'b0;
    if (!cap_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM:  if (rise) state_d = HIGH;
        HIGH: begin
          if (fall) begin
            hi_lat_d = cnt_q;
            state_d  = LOW;
          end else if (timeout) begin
            report_to = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hi_lat_q;
            stuck_d  = 1'b0;
            valid_d  = 1'b1;
            state_d  = HIGH;
          end else if (timeout) begin
            report_to = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Re-arming after a timeout makes the report one-shot per constant stretch
    if (report_to) begin
      period_d    = '0;
      high_d      = '0;
      stuck_d     = 1'b1;
      stuck_lvl_d = s;
      valid_d     = 1'b1;
      state_d     = ARM;
    end
  end

  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      cnt_q       <= '0;
      hi_lat_q    <= '0;
      period_q    <= '0;
      high_q      <= '0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s;
      cnt_q       <= cnt_d;
      hi_lat_q    <= hi_lat_d;
      period_q    <= period_d;
      high_q      <= high_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
      valid_q     <= valid_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign stuck      = stuck_q;
  assign stuck_lvl  = stuck_lvl_q;
  assign meas_valid = valid_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a behavioural PWM generator drives pwm_in,
// results are sampled on the falling clock edge and compared with hand-derived values.
module tb_pwm_capture;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             cap_en;
  logic             pwm_in;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, stuck, stuck_lvl, pwm_level;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_CYC(32'd5000)) dut (
    .Clk50M    (clk),
    .Rst       (rst),
    .cap_en    (cap_en),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .stuck     (stuck),
    .stuck_lvl (stuck_lvl),
    .pwm_level (pwm_level)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned gen_arr = 999;
  int unsigned gen_ccr = 400;
  int unsigned gcnt    = 0;
  bit          gen_en  = 1'b0;

  int          cyc = 0;
  int          n_strobe;
  int          prev_t, last_t;
  logic [31:0] last_period, last_high, first_period, first_high;
  logic        last_stuck, last_lvl;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    n_strobe = 0;
    prev_t   = 0;
    last_t   = 0;
  endtask

  // Sample outputs at the falling edge, then advance the generator one cycle
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (meas_valid === 1'b1) begin
        n_strobe++;
        prev_t      = last_t;
        last_t      = cyc;
        last_period = period;
        last_high   = high_time;
        last_stuck  = stuck;
        last_lvl    = stuck_lvl;
        if (n_strobe == 1) begin
          first_period = period;
          first_high   = high_time;
        end
      end
      if (gen_en) begin
        gcnt   = (gcnt >= gen_arr) ? 0 : gcnt + 1;
        pwm_in = (gcnt < gen_ccr);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    cap_en = 1'b0;
    pwm_in = 1'b0;
    clear_log();
    run_cycles(3);

    check_val("rst_period",    period,     0);
    check_val("rst_high_time", high_time,  0);
    check_val("rst_valid",     meas_valid, 0);
    check_val("rst_stuck",     stuck,      0);
    check_val("rst_stuck_lvl", stuck_lvl,  0);
    check_val("rst_level",     pwm_level,  0);

    rst    = 1'b0;
    cap_en = 1'b1;
    run_cycles(2);

    // 400/1000 waveform
    gen_arr = 999; gen_ccr = 400; gcnt = 999; gen_en = 1'b1;
    clear_log();
    run_cycles(3500);
    check_val("p1_period",  last_period,     1000);
    check_val("p1_high",    last_high,       400);
    check_val("p1_stuck",   last_stuck,      0);
    check_val("p1_spacing", last_t - prev_t, 1000);
    check_val("p1_count",   n_strobe,        3);

    // duty change mid-run; allow one transitional result
    gen_ccr = 700;
    run_cycles(3000);
    check_val("p2_period", last_period, 1000);
    check_val("p2_high",   last_high,   700);

    gen_arr = 499; gen_ccr = 250;
    run_cycles(2000);
    check_val("p3_period", last_period, 500);
    check_val("p3_high",   last_high,   250);
    gen_ccr = 100;
    run_cycles(1500);
    check_val("p3b_high",    last_high,       100);
    check_val("p3b_spacing", last_t - prev_t, 500);

    // constant high level: one timeout report only
    gen_ccr = 600;
    run_cycles(100);
    clear_log();
    run_cycles(12000);
    check_val("to_count",     n_strobe,    1);
    check_val("to_period",    last_period, 0);
    check_val("to_high",      last_high,   0);
    check_val("to_stuck",     last_stuck,  1);
    check_val("to_stuck_lvl", last_lvl,    1);
    check_val("to_stuck_pin", stuck,       1);

    // back to 400/1000, then disable mid-period
    gen_arr = 999; gen_ccr = 400;
    run_cycles(3300);
    check_val("re_period", last_period, 1000);
    cap_en = 1'b0;
    clear_log();
    run_cycles(1500);
    check_val("dis_count",  n_strobe, 0);
    check_val("dis_period", period,   1000);
    check_val("dis_stuck",  stuck,    0);
    cap_en = 1'b1;
    clear_log();
    run_cycles(2500);
    check_val("en_first_period", first_period, 1000);
    check_val("en_first_high",   first_high,   400);

    // reset mid-period clears every output on the next cycle
    run_cycles(250);
    rst = 1'b1;
    run_cycles(1);
    check_val("mrst_period", period,     0);
    check_val("mrst_high",   high_time,  0);
    check_val("mrst_valid",  meas_valid, 0);
    check_val("mrst_stuck",  stuck,      0);
    rst = 1'b0;
    run_cycles(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
